cla_slice_sequencer: RTL and testbench

Sequencer and two-port arbiter for one shared 4-bit carry-lookahead adder slice. The slice exposes sum, group generate and group propagate. This block time-multiplexes the slice to add WIDTH-bit operands one nibble per cycle, LSB nibble first. It forms each nibble's carry-out from the slice's group G/P and keeps the ripple carry in a register. Two requesters share the slice under round-robin arbitration, and one result port returns the sum with the requester ID.

---
 rtl/cla_slice_sequencer.sv | 159 +++++++++++++++
 tb/tb_cla_slice_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cla_slice_sequencer
// Description : Time-multiplexes one shared 4-bit carry-lookahead slice to
//               add WIDTH-bit operands one nibble per cycle (LSB first).
//               Two requesters share it via round-robin; a single result
//               port returns sum, carry-out, signed overflow and requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_slice_sequencer #(
  parameter int  WIDTH  = 16,
  localparam int NSLICE = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_g,
  input  logic             slice_p
);

  localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               last_grant;
  logic               id_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   nib_cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               grant0;
  logic               grant1;
  logic               last_nib;

  assign last_nib = (nib_cnt == CNT_W'(NSLICE - 1));

  // Round-robin grant: only in IDLE, ties go to the requester not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = RUN;
      RUN:     if (last_nib)         state_next = DONE;
      DONE:    if (rsp_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture on grant, nibble-serial accumulation while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      id_reg     <= 1'b0;
      carry_reg  <= 1'b0;
      nib_cnt    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_reg      <= grant1 ? req1_a   : req0_a;
            b_reg      <= grant1 ? req1_b   : req0_b;
            carry_reg  <= grant1 ? req1_cin : req0_cin;
            nib_cnt    <= '0;
            id_reg     <= grant1;
            last_grant <= grant1;
          end
        end
        RUN: begin
          // Ripple carry between nibbles lives only in carry_reg.
          carry_reg <= slice_g | (slice_p & carry_reg);
          nib_cnt   <= last_nib ? '0 : nib_cnt + CNT_W'(1);
          for (int i = 0; i < NSLICE; i++) begin
            if (nib_cnt == CNT_W'(i)) sum_reg[4*i +: 4] <= slice_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Slice drive: current nibble while running, zero otherwise.
  always_comb begin
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_cin = carry_reg;
      for (int i = 0; i < NSLICE; i++) begin
        if (nib_cnt == CNT_W'(i)) begin
          slice_a = a_reg[4*i +: 4];
          slice_b = b_reg[4*i +: 4];
        end
      end
    end
  end

  // Response outputs are presented only in DONE and held until accepted.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state == DONE);
    rsp_sum    = rsp_valid ? sum_reg : '0;
    rsp_cout   = rsp_valid & carry_reg;
    rsp_id     = rsp_valid & id_reg;
    rsp_ovf    = rsp_valid & (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                           & (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_slice_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_slice_sequencer
// Description : Scoreboard bench for cla_slice_sequencer with a behavioural
//               4-bit CLA slice model and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_slice_sequencer;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic [3:0]   slice_a, slice_b, slice_s;
  logic         slice_cin, slice_g, slice_p;

  cla_slice_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_s(slice_s), .slice_g(slice_g), .slice_p(slice_p)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit CLA slice.
  logic [4:0] full5, gen5;
  assign full5   = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};
  assign gen5    = {1'b0, slice_a} + {1'b0, slice_b};
  assign slice_s = full5[3:0];
  assign slice_g = gen5[4];
  assign slice_p = &(slice_a ^ slice_b);

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         id;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;

  // Reference-model state kept at transaction level.
  bit   busy = 1'b0;
  bit   lg   = 1'b1;
  int   since_grant = 0;
  bit   held = 1'b0;
  logic [W-1:0] h_sum;
  logic h_cout, h_ovf, h_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_add(input logic id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
    exp_t e;
    int unsigned u;
    int s;
    u = int'(a) + int'(b) + int'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    e.sum  = W'(u);
    e.cout = (u >> W) != 0;
    e.ovf  = (s > 32767) || (s < -32768);
    e.id   = id;
    return e;
  endfunction

  // Monitor: checks arbitration, latency, stability and scoreboard results.
  initial begin
    exp_t e;
    bit   e0, e1;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; lg = 1; held = 0; since_grant = 0;
        exp_q.delete();
        chk("rst_ready0", {31'd0, req0_ready}, 0);
        chk("rst_ready1", {31'd0, req1_ready}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      end else begin
        e0 = !busy && req0_valid && (!req1_valid || lg);
        e1 = !busy && req1_valid && (!req0_valid || !lg);
        chk("ready0", {31'd0, req0_ready}, {31'd0, e0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, e1});
        if (req0_ready && req1_ready) chk("both_ready", 1, 0);
        if (busy) since_grant++;
        chk("rsp_valid_timing", {31'd0, rsp_valid}, {31'd0, busy && since_grant >= NS + 1});
        if (held) begin
          chk("hold_sum", {16'd0, rsp_sum}, {16'd0, h_sum});
          chk("hold_flags", {28'd0, rsp_valid, rsp_cout, rsp_ovf, rsp_id},
                            {28'd0, 1'b1, h_cout, h_ovf, h_id});
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
            chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          end
          busy = 0;
        end
        held = rsp_valid && !rsp_ready;
        h_sum = rsp_sum; h_cout = rsp_cout; h_ovf = rsp_ovf; h_id = rsp_id;
        if (req0_valid && req0_ready) begin
          exp_q.push_back(ref_add(1'b0, req0_a, req0_b, req0_cin));
          glog.push_back(0); busy = 1; since_grant = 0; lg = 0;
        end else if (req1_valid && req1_ready) begin
          exp_q.push_back(ref_add(1'b1, req1_a, req1_b, req1_cin));
          glog.push_back(1); busy = 1; since_grant = 0; lg = 1;
        end
      end
    end
  end

  // Issue one op on a requester; optionally check slice drive in every RUN cycle.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit chkrun);
    bit got = 0;
    int ua, ub, cexp;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) chk("issue_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (chkrun) begin
      for (int i = 0; i < NS; i++) begin
        @(negedge clk);
        ua = int'(a) & ((1 << (4 * i)) - 1);
        ub = int'(b) & ((1 << (4 * i)) - 1);
        cexp = ((ua + ub + int'(cin)) >> (4 * i)) & 1;
        chk("run_slice_a", {28'd0, slice_a}, (int'(a) >> (4 * i)) & 15);
        chk("run_slice_b", {28'd0, slice_b}, (int'(b) >> (4 * i)) & 15);
        chk("run_slice_cin", {31'd0, slice_cin}, cexp);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  initial begin
    // Reset values.
    #1;
    chk("rst_sum", {16'd0, rsp_sum}, 0);
    chk("rst_slice", {23'd0, slice_a, slice_b, slice_cin}, 0);
    chk("rst_flags", {29'd0, rsp_cout, rsp_ovf, rsp_id}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Directed: basic add, full ripple, signed overflow.
    issue(0, 16'h1234, 16'h4321, 1'b0, 1); wait_idle();
    issue(0, 16'hFFFF, 16'h0000, 1'b1, 1); wait_idle();
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1); wait_idle();

    // Back-pressure for 7 cycles, then grant in the cycle after the handshake.
    rsp_ready = 0;
    issue(0, 16'hA5A5, 16'h5A5A, 1'b1, 0);
    req0_valid = 1; req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) begin @(posedge clk); #1; end
    chk("bp_valid_seen", {31'd0, rsp_valid}, 1);
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_grant_next", {31'd0, req0_ready}, 1);
    @(posedge clk); #1 req0_valid = 0;
    wait_idle();

    // Reset during the second RUN cycle.
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    @(posedge clk); #1;
    chk("pre_rst_slice_a", {28'd0, slice_a}, 15);
    rst = 1; #1;
    chk("midrst_slice", {23'd0, slice_a, slice_b, slice_cin}, 0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Continuous contention after reset: 0,1,0,1.
    glog.delete();
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h8001; req1_cin = 1;
    for (int i = 0; i < 200 && glog.size() < 4; i++) begin @(posedge clk); #1; end
    req0_valid = 0; req1_valid = 0;
    chk("arb_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("arb_order", glog[i], i % 2);
    wait_idle();

    issue(0, 16'h0F0F, 16'h00F1, 1'b0, 1); wait_idle();

    // Randomized contention, operand churn and back-pressure.
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom % 2) == 0; req1_valid = ($urandom % 2) == 0;
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      rsp_ready = ($urandom % 4) != 0;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    wait_idle();
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
